controlador_ascensor: RTL and testbench
=======================================

CONTROLADOR_ASCENSOR -- requirements
Module: controlador_ascensor

Interface
REQ-001 SHALL have parameter T_VIAJE, default 50_000_000, meaning clock cycles the car spends travelling between adjacent floors (minimum 1).
REQ-002 SHALL have parameter T_PUERTA, default 150_000_000, meaning clock cycles the door stays open per stop (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port llamada, input, 4 bits: call buttons, one bit per floor code 0..3, level or pulse, synchronous to clk.
REQ-006 SHALL have port piso, output, 2 bits: current floor code (0 = basement "-1", 1..3 = floors 1..3); feeds the display controller directly.
REQ-007 SHALL have port puerta_abierta, output, 1 bit: high while the door is open.
REQ-008 SHALL have port subiendo, output, 1 bit: high while the car moves up.
REQ-009 SHALL have port bajando, output, 1 bit: high while the car moves down.
REQ-010 SHALL have port pendientes, output, 4 bits: latched, not-yet-served calls.

Function
REQ-011 SHALL implement a three-state FSM: REPOSO, MOVIENDO, PUERTA.
REQ-012 SHALL set the pendientes bit at the clock edge following any cycle where the corresponding llamada bit is high; bits SHALL clear only on service (REQ-015, REQ-018).
REQ-013 SHALL take the REPOSO decision from the effective request vector pendientes | llamada, so a call reacts with one-cycle latency.
REQ-014 SHALL keep a direction register (dir_arriba), initially up. In REPOSO: if requests exist ahead in dir, move that way; else if requests exist behind, reverse and move; else stay in REPOSO.
REQ-015 SHALL treat a request at the current floor in REPOSO as taking priority over motion: go to PUERTA at the next edge and clear that bit.
REQ-016 SHALL, in MOVIENDO, update piso by +1/-1 on the T_VIAJE-th cycle after entry, then reload the timer.
REQ-017 SHALL never let piso go below 0 or above 3; no wrap-around. Motion starts only toward an existing request, and a request bit is cleared only on arrival, so the bound always holds.
REQ-018 SHALL handle arrival on the same edge as the piso update: if the new floor's effective request bit is set, go to PUERTA and clear it; otherwise stay in MOVIENDO.
REQ-019 SHALL hold PUERTA for T_PUERTA cycles, then go to REPOSO.
REQ-020 SHALL restart the door timer if a call for the current floor arrives during PUERTA, and SHALL NOT latch that call.
REQ-021 SHALL drive outputs as registered or decoded from registered state:
- puerta_abierta = (state == PUERTA)
- subiendo = MOVIENDO & dir_arriba
- bajando = MOVIENDO & ~dir_arriba
- subiendo and bajando are never both high.
REQ-022 SHALL latch calls for other floors arriving in any state without disturbing the current travel or door timing.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force:
- state REPOSO, piso 0, pendientes 0, dir_arriba 1
- both timers 0
- all outputs low except piso = 0
REQ-024 SHALL abandon any motion or open door when reset is asserted mid-operation; after release the car is idle at floor code 0 and no calls are remembered.

Structure
REQ-025 SHALL place the FSM state encoding, the floor constants (PISO_SUBTERRANEO=0, PISO_MAX=3) and the floor count in a shared package used by this block and the display controller.
REQ-026 SHALL instantiate sub-module temporizador twice (travel, door): a parameterised load/enable down-counter with a one-cycle done pulse.

Verification (T_VIAJE=4, T_PUERTA=3; call pulses 1 cycle at cycle N)
REQ-027 SHALL cover: idle at 0, llamada=0100 -> MOVIENDO and subiendo=1 at N+1; piso=1 at N+5; piso=2 and puerta_abierta=1 at N+9; REPOSO at N+12; pendientes=0.
REQ-028 SHALL cover: idle at 0, llamada=0001 -> puerta_abierta=1 at N+1, no motion, pendientes stays 0.
REQ-029 SHALL cover: at 0, llamada=1000, then llamada=0010 at N+2 -> stop at 1 first (door at N+5), then continue to 3; bajando never asserted.
REQ-030 SHALL cover: at 2 moving up to 3 with a latched call for 0 -> serve 3, then reverse: bajando=1, piso 3->2->1->0, door opens at 0.
REQ-031 SHALL cover: during PUERTA at floor 1, llamada=0010 on the door's last cycle -> door stays open 3 further cycles.
REQ-032 SHALL cover: rst_n pulled low mid-travel between floors 1 and 2 -> immediately piso=0, outputs low, pendientes=0; no motion after release.

Source files
------------

// File: rtl/controlador_ascensor_pkg.sv
// Shared constants for the elevator block and the floor display controller.
package controlador_ascensor_pkg;

    localparam int NUM_PISOS = 4;

    typedef logic [1:0] piso_t;

    localparam piso_t PISO_SUBTERRANEO = 2'd0;
    localparam piso_t PISO_MAX         = 2'd3;

    // Controller FSM encoding
    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] MOVIENDO = 2'd1;
    localparam logic [1:0] PUERTA   = 2'd2;

    // Floors strictly above p
    function automatic logic [NUM_PISOS-1:0] mascara_arriba(input piso_t p);
        logic [NUM_PISOS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_PISOS; i++)
            if (i > int'(p)) m[i] = 1'b1;
        return m;
    endfunction

    // Floors strictly below p
    function automatic logic [NUM_PISOS-1:0] mascara_abajo(input piso_t p);
        logic [NUM_PISOS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_PISOS; i++)
            if (i < int'(p)) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/controlador_ascensor_if.sv
// Call buttons in, car status out.
interface controlador_ascensor_if;
    import controlador_ascensor_pkg::*;

    logic [NUM_PISOS-1:0] llamada;
    piso_t                piso;
    logic                 puerta_abierta;
    logic                 subiendo;
    logic                 bajando;
    logic [NUM_PISOS-1:0] pendientes;

    modport master (
        output llamada,
        input  piso, puerta_abierta, subiendo, bajando, pendientes
    );

    modport slave (
        input  llamada,
        output piso, puerta_abierta, subiendo, bajando, pendientes
    );

endinterface

// File: rtl/controlador_ascensor_temporizador.sv
// Loadable down-counter; fin pulses on the CICLOS-th enabled cycle after carga.
module temporizador #(
    parameter int CICLOS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic carga,
    input  logic habilita,
    output logic fin
);

    localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;

    logic [W-1:0] cnt;

    // Load to CICLOS-1 so the zero count is the last cycle of the interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (carga)
            cnt <= W'(CICLOS - 1);
        else if (habilita && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign fin = habilita && (cnt == '0);

endmodule

// File: rtl/controlador_ascensor.sv
// Four-floor elevator controller: collective up/down scheduling with door hold.
module controlador_ascensor
    import controlador_ascensor_pkg::*;
#(
    parameter int T_VIAJE  = 50_000_000,
    parameter int T_PUERTA = 150_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    controlador_ascensor_if.slave       bus
);

    logic [1:0]           estado, estado_sig;
    piso_t                piso_q, piso_sig, piso_paso;
    logic                 dir_arriba, dir_sig;
    logic [NUM_PISOS-1:0] pend_q, pend_sig, efectiva;
    logic                 hay_arriba, hay_abajo, hay_delante, hay_detras;
    logic                 viaje_carga, viaje_en, viaje_fin;
    logic                 puerta_carga, puerta_en, puerta_fin;

    assign efectiva    = pend_q | bus.llamada;
    assign hay_arriba  = |(efectiva & mascara_arriba(piso_q));
    assign hay_abajo   = |(efectiva & mascara_abajo(piso_q));
    assign hay_delante = dir_arriba ? hay_arriba : hay_abajo;
    assign hay_detras  = dir_arriba ? hay_abajo  : hay_arriba;
    assign piso_paso   = dir_arriba ? piso_q + 2'd1 : piso_q - 2'd1;
    assign viaje_en    = (estado == MOVIENDO);
    assign puerta_en   = (estado == PUERTA);

    // Next-state, floor, direction and pending-call bookkeeping
    always_comb begin
        estado_sig   = estado;
        piso_sig     = piso_q;
        dir_sig      = dir_arriba;
        pend_sig     = efectiva;
        viaje_carga  = 1'b0;
        puerta_carga = 1'b0;
        case (estado)
            REPOSO: begin
                if (efectiva[piso_q]) begin
                    estado_sig       = PUERTA;
                    puerta_carga     = 1'b1;
                    pend_sig[piso_q] = 1'b0;
                end else if (hay_delante) begin
                    estado_sig  = MOVIENDO;
                    viaje_carga = 1'b1;
                end else if (hay_detras) begin
                    dir_sig     = ~dir_arriba;
                    estado_sig  = MOVIENDO;
                    viaje_carga = 1'b1;
                end
            end
            MOVIENDO: begin
                if (viaje_fin) begin
                    piso_sig = piso_paso;
                    if (efectiva[piso_paso]) begin
                        estado_sig          = PUERTA;
                        puerta_carga        = 1'b1;
                        pend_sig[piso_paso] = 1'b0;
                    end else begin
                        viaje_carga = 1'b1;
                    end
                end
            end
            PUERTA: begin
                // A call for the open floor only extends the door, never latches
                pend_sig[piso_q] = 1'b0;
                if (bus.llamada[piso_q])
                    puerta_carga = 1'b1;
                else if (puerta_fin)
                    estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= REPOSO;
            piso_q     <= PISO_SUBTERRANEO;
            dir_arriba <= 1'b1;
            pend_q     <= '0;
        end else begin
            estado     <= estado_sig;
            piso_q     <= piso_sig;
            dir_arriba <= dir_sig;
            pend_q     <= pend_sig;
        end
    end

    temporizador #(.CICLOS(T_VIAJE)) u_viaje (
        .clk      (clk),
        .rst_n    (rst_n),
        .carga    (viaje_carga),
        .habilita (viaje_en),
        .fin      (viaje_fin)
    );

    temporizador #(.CICLOS(T_PUERTA)) u_puerta (
        .clk      (clk),
        .rst_n    (rst_n),
        .carga    (puerta_carga),
        .habilita (puerta_en),
        .fin      (puerta_fin)
    );

    assign bus.piso           = piso_q;
    assign bus.puerta_abierta = puerta_en;
    assign bus.subiendo       = viaje_en & dir_arriba;
    assign bus.bajando        = viaje_en & ~dir_arriba;
    assign bus.pendientes     = pend_q;

endmodule

// File: tb/tb_controlador_ascensor.sv
// Scoreboard bench: directed scenarios plus random calls against a cycle-level model.
module tb_controlador_ascensor;

    localparam int T_VIAJE  = 4;
    localparam int T_PUERTA = 3;
    localparam int REP = 0, VIA = 1, PUE = 2;

    typedef struct packed {
        logic [1:0] piso;
        logic       puerta;
        logic       sube;
        logic       baja;
        logic [3:0] pend;
    } salida_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    salida_t esperado_q[$];

    controlador_ascensor_if bus();

    controlador_ascensor #(.T_VIAJE(T_VIAJE), .T_PUERTA(T_PUERTA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: floor, mode, remaining cycles in mode, heading, pending set
    int       m_piso, m_modo, m_rest;
    bit       m_arriba;
    bit [3:0] m_pend;

    task automatic modelo_reset();
        m_piso = 0; m_modo = REP; m_rest = 0; m_arriba = 1'b1; m_pend = '0;
    endtask

    task automatic modelo_paso(input logic [3:0] l);
        bit [3:0] ef;
        bit arr_hay, aba_hay;
        ef = m_pend | l;
        m_pend = ef;
        arr_hay = 0; aba_hay = 0;
        for (int i = 0; i < 4; i++) begin
            if (ef[i] && i > m_piso) arr_hay = 1;
            if (ef[i] && i < m_piso) aba_hay = 1;
        end
        case (m_modo)
            REP: begin
                if (ef[m_piso]) begin
                    m_modo = PUE; m_rest = T_PUERTA; m_pend[m_piso] = 1'b0;
                end else if (m_arriba ? arr_hay : aba_hay) begin
                    m_modo = VIA; m_rest = T_VIAJE;
                end else if (arr_hay || aba_hay) begin
                    m_arriba = !m_arriba; m_modo = VIA; m_rest = T_VIAJE;
                end
            end
            VIA: begin
                m_rest--;
                if (m_rest == 0) begin
                    m_piso = m_piso + (m_arriba ? 1 : -1);
                    if (ef[m_piso]) begin
                        m_modo = PUE; m_rest = T_PUERTA; m_pend[m_piso] = 1'b0;
                    end else begin
                        m_rest = T_VIAJE;
                    end
                end
            end
            default: begin
                m_pend[m_piso] = 1'b0;
                if (l[m_piso]) m_rest = T_PUERTA;
                else begin
                    m_rest--;
                    if (m_rest == 0) m_modo = REP;
                end
            end
        endcase
    endtask

    function automatic salida_t modelo_salida();
        salida_t s;
        s.piso   = m_piso[1:0];
        s.puerta = (m_modo == PUE);
        s.sube   = (m_modo == VIA) && m_arriba;
        s.baja   = (m_modo == VIA) && !m_arriba;
        s.pend   = m_pend;
        return s;
    endfunction

    task automatic chequear(input string nombre, input int actual, input int esperado);
        checks++;
        if (actual != esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nombre, actual, esperado, $time);
        end
    endtask

    // One cycle of stimulus; the expected post-edge outputs go to the scoreboard
    task automatic ciclo(input logic [3:0] l, input logic r);
        @(negedge clk);
        rst_n = r;
        bus.llamada = l;
        if (!r) begin
            modelo_reset();
            #1;
            chequear("reset_piso", int'(bus.piso), 0);
            chequear("reset_salidas", int'({bus.puerta_abierta, bus.subiendo, bus.bajando}), 0);
            chequear("reset_pend", int'(bus.pendientes), 0);
        end else begin
            modelo_paso(l);
        end
        esperado_q.push_back(modelo_salida());
    endtask

    task automatic ciclos(input int n);
        for (int i = 0; i < n; i++) ciclo(4'b0000, 1'b1);
    endtask

    // Monitor: compare every post-edge output sample against the scoreboard
    initial begin
        salida_t exp_s, got_s;
        forever begin
            @(posedge clk);
            #1;
            if (esperado_q.size() > 0) begin
                exp_s = esperado_q.pop_front();
                got_s.piso   = bus.piso;
                got_s.puerta = bus.puerta_abierta;
                got_s.sube   = bus.subiendo;
                got_s.baja   = bus.bajando;
                got_s.pend   = bus.pendientes;
                checks++;
                if (got_s !== exp_s) begin
                    errors++;
                    $display("FAIL salidas @%0t: got piso=%0d pa=%b sub=%b baj=%b pend=%b expected piso=%0d pa=%b sub=%b baj=%b pend=%b",
                             $time, got_s.piso, got_s.puerta, got_s.sube, got_s.baja, got_s.pend,
                             exp_s.piso, exp_s.puerta, exp_s.sube, exp_s.baja, exp_s.pend);
                end
            end
        end
    end

    initial begin
        logic [3:0] l;
        logic       r;
        bus.llamada = '0;
        modelo_reset();
        ciclo(4'b0000, 1'b0);
        ciclo(4'b0000, 1'b0);
        ciclos(2);

        // Call at the current floor opens the door next cycle, nothing latched
        ciclo(4'b0001, 1'b1);
        ciclo(4'b0000, 1'b1);
        chequear("c028_puerta", int'(bus.puerta_abierta), 1);
        chequear("c028_pend", int'(bus.pendientes), 0);
        ciclos(3);
        chequear("c028_reposo", int'(bus.puerta_abierta), 0);

        // 0 -> 2 trip timing
        ciclo(4'b0100, 1'b1);
        ciclo(4'b0000, 1'b1);
        chequear("c027_subiendo", int'(bus.subiendo), 1);
        ciclos(4);
        chequear("c027_piso1", int'(bus.piso), 1);
        ciclos(4);
        chequear("c027_piso2", int'(bus.piso), 2);
        chequear("c027_puerta", int'(bus.puerta_abierta), 1);
        ciclos(3);
        chequear("c027_reposo", int'({bus.puerta_abierta, bus.subiendo, bus.bajando}), 0);
        chequear("c027_pend", int'(bus.pendientes), 0);

        ciclo(4'b0000, 1'b0);
        ciclos(1);

        // Intermediate stop picked up on the way to 3
        ciclo(4'b1000, 1'b1);
        ciclo(4'b0000, 1'b1);
        ciclo(4'b0010, 1'b1);
        ciclos(3);
        chequear("c029_parada1", int'(bus.piso), 1);
        chequear("c029_puerta1", int'(bus.puerta_abierta), 1);
        ciclos(12);
        chequear("c029_piso3", int'(bus.piso), 3);
        chequear("c029_puerta3", int'(bus.puerta_abierta), 1);
        ciclos(3);

        // 3 -> 2, then up to 3 with a call for 0 latched on the way: reverse after 3
        ciclo(4'b0100, 1'b1);
        ciclo(4'b0000, 1'b1);
        chequear("c030_baja_a2", int'(bus.bajando), 1);
        ciclos(7);
        ciclo(4'b1000, 1'b1);
        ciclo(4'b0000, 1'b1);
        chequear("c030_sube", int'(bus.subiendo), 1);
        ciclo(4'b0001, 1'b1);
        ciclos(3);
        chequear("c030_piso3", int'(bus.piso), 3);
        chequear("c030_pend0", int'(bus.pendientes), 1);
        ciclos(4);
        chequear("c030_bajando", int'(bus.bajando), 1);
        ciclos(12);
        chequear("c030_piso0", int'(bus.piso), 0);
        chequear("c030_puerta0", int'(bus.puerta_abierta), 1);
        ciclos(3);

        // Door restart by a call for the open floor on its last cycle
        ciclo(4'b0010, 1'b1);
        ciclos(6);
        ciclo(4'b0010, 1'b1);
        chequear("c031_ultimo", int'(bus.puerta_abierta), 1);
        ciclo(4'b0000, 1'b1);
        chequear("c031_pend", int'(bus.pendientes), 0);
        ciclos(2);
        chequear("c031_extendida", int'(bus.puerta_abierta), 1);
        ciclos(1);
        chequear("c031_cierra", int'(bus.puerta_abierta), 0);

        // Reset mid-travel from 1 toward 2
        ciclo(4'b1100, 1'b1);
        ciclo(4'b0000, 1'b1);
        chequear("c032_pend", int'(bus.pendientes), 12);
        ciclo(4'b0000, 1'b1);
        ciclo(4'b0000, 1'b0);
        ciclos(10);
        chequear("c032_quieto", int'({bus.piso, bus.subiendo, bus.bajando}), 0);

        // Random traffic with rare resets
        for (int k = 0; k < 800; k++) begin
            l = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            r = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            ciclo(l, r);
        end
        ciclos(2);

        @(posedge clk);
        #2;
        checks++;
        if (esperado_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_vacio: got %0d entries expected 0", esperado_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
